// File: rtl/uart_word_rx.sv
// 8N1 UART receiver that packs four bytes (MSB first) into 32-bit words
// and queues them in a small first-word-fall-through FIFO.
module uart_word_rx #(
    parameter int unsigned CLK_PER_BIT = 16,
    parameter int unsigned FIFO_AW     = 2
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        rx,
    input  logic        ack,
    output logic [31:0] input_data,
    output logic        input_ready,
    output logic        overrun,
    output logic        framing_error
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned TW    = $clog2(CLK_PER_BIT);

    localparam logic [TW-1:0]      TICK_HALF_M1 = TW'(CLK_PER_BIT / 2 - 1);
    localparam logic [TW-1:0]      TICK_FULL_M1 = TW'(CLK_PER_BIT - 1);
    localparam logic [TW-1:0]      TICK_ONE     = TW'(1);
    localparam logic [FIFO_AW:0]   DEPTH_C      = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   PTR_LAST     = (FIFO_AW + 1)'(DEPTH - 1);
    localparam logic [FIFO_AW:0]   CNT_ONE      = (FIFO_AW + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic                r_sync1;
    logic                r_sync2;
    state_t              r_state;
    logic [TW-1:0]       r_tick;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic [1:0]          r_byte_cnt;
    logic [31:0]         r_word;
    logic [31:0]         r_mem [DEPTH];
    logic [FIFO_AW:0]    r_rd_ptr;
    logic [FIFO_AW:0]    r_wr_ptr;
    logic [FIFO_AW:0]    r_count;
    logic                r_overrun;
    logic                r_framing_error;

    state_t              w_state_nxt;
    logic [TW-1:0]       w_tick_nxt;
    logic [2:0]          w_bit_nxt;
    logic [7:0]          w_shift_nxt;
    logic                w_byte_ok;
    logic                w_stop_bad;
    logic                w_push;
    logic [31:0]         w_push_word;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_wr;
    logic                w_drop;

    function automatic logic [FIFO_AW:0] ptr_inc(input logic [FIFO_AW:0] p);
        return (p == PTR_LAST) ? '0 : p + CNT_ONE;
    endfunction

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_tick    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tick    <= w_tick_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_byte_ok   = 1'b0;
        w_stop_bad  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_sync2) begin
                    w_tick_nxt  = TICK_HALF_M1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_tick != '0) begin
                    w_tick_nxt = r_tick - TICK_ONE;
                end else if (!r_sync2) begin
                    w_tick_nxt  = TICK_FULL_M1;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_DATA;
                end else begin
                    // start bit vanished by mid-bit: treat as a line glitch
                    w_state_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                if (r_tick != '0) begin
                    w_tick_nxt = r_tick - TICK_ONE;
                end else begin
                    w_shift_nxt = {r_sync2, r_shift[7:1]};
                    w_tick_nxt  = TICK_FULL_M1;
                    w_bit_nxt   = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (r_tick != '0) begin
                    w_tick_nxt = r_tick - TICK_ONE;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_byte_ok   = r_sync2;
                    w_stop_bad  = !r_sync2;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The fourth byte bypasses r_word and goes straight into the FIFO.
    assign w_push      = w_byte_ok && (r_byte_cnt == 2'd3);
    assign w_push_word = {r_word[31:8], r_shift};

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_byte_cnt <= '0;
            r_word     <= '0;
        end else if (w_stop_bad) begin
            r_byte_cnt <= '0;
        end else if (w_byte_ok) begin
            case (r_byte_cnt)
                2'd0:    r_word[31:24] <= r_shift;
                2'd1:    r_word[23:16] <= r_shift;
                2'd2:    r_word[15:8]  <= r_shift;
                default: r_word[7:0]   <= r_shift;
            endcase
            r_byte_cnt <= r_byte_cnt + 2'd1;
        end
    end

    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);
    assign w_pop   = ack && !w_empty;
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= w_push_word;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_overrun       <= 1'b0;
            r_framing_error <= 1'b0;
        end else begin
            r_overrun       <= w_drop;
            r_framing_error <= w_stop_bad;
        end
    end

    assign input_data    = w_empty ? '0 : r_mem[r_rd_ptr[FIFO_AW-1:0]];
    assign input_ready   = !w_empty;
    assign overrun       = r_overrun;
    assign framing_error = r_framing_error;

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed + randomized bench for uart_word_rx; expected words come from a
// byte-list/queue model of framing, word packing and the 4-deep FIFO.
module tb_uart_word_rx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        ack = 1'b0;
    logic [31:0] input_data;
    logic        input_ready;
    logic        overrun;
    logic        framing_error;

    int n_cmp = 0;
    int n_bad = 0;
    int ov_cnt = 0;
    int fe_cnt = 0;
    int ov_exp = 0;
    int fe_exp = 0;

    logic [31:0] exp_q [$];
    logic [7:0]  part_q [$];
    logic [31:0] wv [5];
    logic [7:0]  bv;
    logic [31:0] tmp;

    uart_word_rx #(
        .CLK_PER_BIT(CPB),
        .FIFO_AW(2)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .rx(rx),
        .ack(ack),
        .input_data(input_data),
        .input_ready(input_ready),
        .overrun(overrun),
        .framing_error(framing_error)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        #1;
        if (overrun === 1'b1) ov_cnt++;
        if (framing_error === 1'b1) fe_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        rx = 1'b1;
    endtask

    // Reference: good bytes accumulate, a bad stop discards the partial word.
    task automatic model_frame(input logic [7:0] b, input logic stop, input logic ackd);
        if (stop) begin
            part_q.push_back(b);
            if (part_q.size() == 4) begin
                tmp = {part_q[0], part_q[1], part_q[2], part_q[3]};
                part_q.delete();
                if (ackd && exp_q.size() > 0) void'(exp_q.pop_front());
                if (exp_q.size() < DEPTH) exp_q.push_back(tmp);
                else ov_exp++;
            end
        end else begin
            part_q.delete();
            fe_exp++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_frame(b, stop);
        model_frame(b, stop, 1'b0);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], 1'b1);
    endtask

    task automatic pop();
        ack = 1'b1;
        @(posedge CLK);
        #1;
        ack = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic check_head(input string tag);
        if (exp_q.size() > 0) begin
            check({tag, "_ready"}, {31'd0, input_ready}, 32'd1);
            check({tag, "_data"}, input_data, exp_q[0]);
        end else begin
            check({tag, "_ready"}, {31'd0, input_ready}, 32'd0);
            check({tag, "_data"}, input_data, 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1;
        cycles(5);
        check("rst_ready", {31'd0, input_ready}, 32'd0);
        check("rst_data", input_data, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_ferr", {31'd0, framing_error}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 100; i++) begin
            cycles(1);
            check("idle_ready", {31'd0, input_ready}, 32'd0);
            check("idle_data", input_data, 32'd0);
        end
        check("idle_ov_cnt", ov_cnt, 32'd0);
        check("idle_fe_cnt", fe_cnt, 32'd0);

        send_word(32'hDEADBEEF);
        cycles(2);
        check("dead_data_const", input_data, 32'hDEADBEEF);
        check_head("dead");
        pop();
        check_head("dead_after_ack");

        rx = 1'b0;
        cycles(CPB / 4);
        rx = 1'b1;
        cycles(3 * CPB);
        check("glitch_ready", {31'd0, input_ready}, 32'd0);
        send_word(32'h01020304);
        cycles(2);
        check("glitch_word_const", input_data, 32'h01020304);
        check_head("glitch");
        pop();
        check_head("glitch_after_ack");
        check("glitch_fe_cnt", fe_cnt, 32'd0);

        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'($urandom), 1'b0);
        cycles(2 * CPB);
        send_word(32'hAABBCCDD);
        cycles(2);
        check("ferr_cnt", fe_cnt, fe_exp);
        check("ferr_cnt_const", fe_cnt, 32'd1);
        check("ferr_word_const", input_data, 32'hAABBCCDD);
        check_head("ferr");
        pop();
        check_head("ferr_after_ack");

        for (int k = 0; k < 5; k++) begin
            wv[k] = $urandom;
            send_word(wv[k]);
        end
        cycles(2);
        check("ovr_cnt", ov_cnt, ov_exp);
        check("ovr_cnt_const", ov_cnt, 32'd1);
        check("ovr_head_const", input_data, wv[0]);
        for (int k = 0; k < 4; k++) begin
            check("ovr_order", input_data, wv[k]);
            check_head("ovr_drain");
            pop();
        end
        check_head("ovr_empty");

        for (int k = 0; k < 4; k++) begin
            wv[k] = $urandom;
            send_word(wv[k]);
        end
        wv[4] = $urandom;
        for (int k = 0; k < 3; k++) send_byte(wv[4][31-8*k -: 8], 1'b1);
        // ack lands on the edge that samples the last stop bit
        fork
            send_frame(wv[4][7:0], 1'b1);
            begin
                repeat (2 + CPB / 2 + 9 * CPB) @(posedge CLK);
                #1;
                ack = 1'b1;
                @(posedge CLK);
                #1;
                ack = 1'b0;
            end
        join
        model_frame(wv[4][7:0], 1'b1, 1'b1);
        cycles(2);
        check("ackpush_ov_cnt", ov_cnt, ov_exp);
        check("ackpush_ov_const", ov_cnt, 32'd1);
        for (int k = 1; k < 5; k++) begin
            check("ackpush_order", input_data, wv[k]);
            check_head("ackpush_drain");
            pop();
        end
        check_head("ackpush_empty");

        send_word($urandom);
        bv = 8'($urandom);
        send_byte(bv, 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(bv[i] ^ 1'b1);
        rx = ~bv[4];
        cycles(CPB / 2);
        reset = 1'b1;
        cycles(2);
        check("midrst_ready", {31'd0, input_ready}, 32'd0);
        check("midrst_data", input_data, 32'd0);
        reset = 1'b0;
        rx = 1'b1;
        exp_q.delete();
        part_q.delete();
        cycles(2 * CPB);
        check_head("midrst_empty");
        tmp = $urandom;
        wv[0] = tmp;
        send_word(wv[0]);
        cycles(2);
        check("midrst_word", input_data, wv[0]);
        check_head("midrst_new");
        pop();
        check_head("midrst_after_ack");

        for (int r = 0; r < 3; r++) begin
            send_word($urandom);
            cycles(2);
            check_head("rand_word");
            if ($urandom_range(0, 1) == 1) begin
                pop();
                check_head("rand_pop");
            end
        end
        while (exp_q.size() > 0) begin
            pop();
            check_head("rand_drain");
        end
        check("final_ov_cnt", ov_cnt, ov_exp);
        check("final_fe_cnt", fe_cnt, fe_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_word_rx.md
# uart_word_rx

Serial receiver that feeds the register-write stage's UART input path. It deserializes 8N1 UART frames from the `rx` pin and assembles every four bytes into a 32-bit word, most-significant byte first. Completed words go into a small first-word-fall-through FIFO, which the downstream stage reads through `input_data`/`input_ready` and pops with `ack`.

## Interface
- CLK_PER_BIT, default 16 — clock cycles per UART bit; must be even and ≥ 4.
- FIFO_AW, default 2 — FIFO address width; the FIFO holds 2^FIFO_AW words (default 4).

- CLK  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous UART line; idles high.
- ack  input  1  consumer pop strobe; pops the head word when `input_ready` is 1.
- input_data  output  32  FIFO head word; valid only while `input_ready` is 1.
- input_ready  output  1  FIFO not empty.
- overrun  output  1  one-cycle pulse: a completed word was dropped because the FIFO was full.
- framing_error  output  1  one-cycle pulse: stop bit sampled low.

## Operation
- **Input sync:** `rx` passes through two flops to give `rx_s`. Both flops reset to 1.
- **Receiver FSM**, with a bit-timer `tick_cnt` (width ≥ log2(CLK_PER_BIT)) and a 3-bit `bit_idx`:
  - IDLE: when `rx_s` is 0, load `tick_cnt` = CLK_PER_BIT/2 − 1 and go to START.
  - START: count `tick_cnt` down to 0, then sample `rx_s`.
    - Sampled 0: load `tick_cnt` = CLK_PER_BIT − 1, set `bit_idx` = 0, go to DATA.
    - Sampled 1: the start bit was a glitch; return to IDLE with no other effect.
  - DATA: at each `tick_cnt` = 0, shift `rx_s` into the byte register, LSB first, and reload the timer. After bit 7, go to STOP.
  - STOP: at `tick_cnt` = 0, sample `rx_s`.
    - Sampled 1: the byte is complete.
    - Sampled 0: pulse `framing_error`, discard the byte, and clear the partial word (byte counter → 0).
    - Either way, return to IDLE. A new start bit can be detected the cycle after return.
- **Word assembly:** a 2-bit byte counter places each completed byte.
  - Byte 0 → [31:24], byte 1 → [23:16], byte 2 → [15:8], byte 3 → [7:0].
  - On byte 3, the assembled word is pushed and the counter wraps to 0.
- **FIFO:** read pointer, write pointer and count, each FIFO_AW+1 bits; pointers wrap modulo the depth.
  - Push when count < depth. Also push when full if `ack` pops in the same cycle; the simultaneous pop makes room.
  - Push when full without a pop: drop the word and pulse `overrun`. FIFO contents are unchanged.
  - Pop when `ack` && count > 0. `ack` while empty is ignored.
  - Push and pop in the same cycle leave the count unchanged.
  - `input_data` is the head entry (fall-through). It reads 0 when empty.
- **Reset:** FSM → IDLE, counters and pointers → 0, byte counter → 0, word register → 0. All outputs reset to 0: `input_data`, `input_ready`, `overrun`, `framing_error`.
- **Reset mid-frame:** the partial byte, the partial word and every FIFO entry are lost. The receiver rearms in IDLE.

## Timing
- Start detection takes effect 2 cycles after `rx` falls, because of the synchronizer.
- Data bit k (k = 0..7) is sampled CLK_PER_BIT/2 + (k+1)·CLK_PER_BIT cycles after detection. The stop bit is sampled at CLK_PER_BIT/2 + 9·CLK_PER_BIT.
- The FIFO write happens on the edge that samples the stop bit of byte 3. `input_ready` rises 1 cycle later.
- Pop on an `ack` edge. On the following cycle, `input_data` shows the next word, or `input_ready` is 0.
- `overrun` and `framing_error` are high for exactly one cycle, aligned with the stop-bit sample edge.
- Back-to-back frames with a single stop bit (10·CLK_PER_BIT per byte) are received without loss.

## Test plan
- After reset, `rx` = 1 for 100 cycles → `input_ready` = 0, `input_data` = 0, no error pulses.
- Send bytes 0xDE, 0xAD, 0xBE, 0xEF, then pulse `ack` → after the last stop bit, `input_ready` = 1 with `input_data` = 0xDEADBEEF; after `ack`, `input_ready` = 0.
- A 0.25-bit low glitch on `rx` in IDLE, then bytes 0x01 0x02 0x03 0x04 → no spurious byte; word = 0x01020304.
- Bytes 0x11 0x22, then a frame with stop bit 0, then 0xAA 0xBB 0xCC 0xDD → one `framing_error` pulse; the only word is 0xAABBCCDD.
- Five words with no `ack` → four words are held in order. On the 5th word, `overrun` pulses and the head stays word 1. With `ack` asserted at the 5th push edge, there is no overrun and the 5th word is stored.
- `reset` asserted during bit 4 of the second byte, then a full 4-byte word sent → FIFO empty after reset; the new word is received correctly.
